// File: rtl/ring_pkg.sv
//------------------------------------------------------------------------------
// ring_pkg: shared types and constants for the LED ring sequencer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package ring_pkg;

  localparam int NBITS_RING = 4;
  localparam logic [NBITS_RING-1:0] RING_INIT = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic is_onehot(input logic [NBITS_RING-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ring_sequencer_if.sv
//------------------------------------------------------------------------------
// ring_sequencer_if: control inputs and status outputs of the ring sequencer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface ring_sequencer_if #(
  parameter int NBITS_STEPS = 8,
  parameter int NBITS_PRESC = 8
);
  import ring_pkg::*;

  logic                   start;
  logic                   stop;
  logic                   pause;
  logic                   dir;
  logic [NBITS_STEPS-1:0] steps;
  logic [NBITS_PRESC-1:0] presc;
  logic [NBITS_RING-1:0]  ring;
  logic                   busy;
  logic                   done;
  logic [1:0]             state;

  modport master (
    output start, stop, pause, dir, steps, presc,
    input  ring, busy, done, state
  );

  modport slave (
    input  start, stop, pause, dir, steps, presc,
    output ring, busy, done, state
  );

endinterface

`default_nettype wire

// File: rtl/ring_sequencer_tick_gen.sv
//------------------------------------------------------------------------------
// tick_gen: step-rate prescaler; o_tick fires when the count reaches i_load.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tick_gen #(
  parameter int NBITS_PRESC = 8
) (
  input  logic                   clk_2,
  input  logic                   reset,
  input  logic                   i_en,
  input  logic                   i_clr,
  input  logic [NBITS_PRESC-1:0] i_load,
  output logic                   o_tick
);

  logic [NBITS_PRESC-1:0] r_pcnt;

  assign o_tick = i_en && (r_pcnt == i_load);

  // Count is frozen whenever i_en is low, so a pause resumes mid-period.
  always_ff @(posedge clk_2) begin
    if (reset || i_clr) begin
      r_pcnt <= '0;
    end else if (i_en) begin
      r_pcnt <= o_tick ? '0 : r_pcnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ring_sequencer.sv
//------------------------------------------------------------------------------
// ring_sequencer: FSM that steps a one-hot LED ring, counted or continuous.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ring_sequencer
  import ring_pkg::*;
#(
  parameter int NBITS_STEPS = 8,
  parameter int NBITS_PRESC = 8
) (
  input  logic             clk_2,
  input  logic             reset,
  ring_sequencer_if.slave  bus
);

  state_t                 r_state,     w_state_nxt;
  logic [NBITS_RING-1:0]  r_ring,      w_ring_nxt;
  logic [NBITS_STEPS-1:0] r_remaining, w_rem_nxt;
  logic                   r_counted,   w_counted_nxt;
  logic [NBITS_PRESC-1:0] r_presc_q,   w_presc_nxt;
  logic                   r_busy;
  logic                   r_done;
  logic                   w_en;
  logic                   w_clr;
  logic                   w_tick;
  logic [NBITS_RING-1:0]  w_ring_step;

  // HOLD also counts on its release edge so a pause adds exactly its length.
  assign w_en  = ((r_state == ST_RUN) || (r_state == ST_HOLD)) && !bus.stop && !bus.pause;
  assign w_clr = (r_state == ST_IDLE) && bus.start && !bus.stop;

  tick_gen #(
    .NBITS_PRESC (NBITS_PRESC)
  ) u_tick_gen (
    .clk_2  (clk_2),
    .reset  (reset),
    .i_en   (w_en),
    .i_clr  (w_clr),
    .i_load (r_presc_q),
    .o_tick (w_tick)
  );

  always_comb begin
    w_ring_step = RING_INIT;
    if (is_onehot(r_ring)) begin
      w_ring_step = bus.dir ? {r_ring[0], r_ring[NBITS_RING-1:1]}
                            : {r_ring[NBITS_RING-2:0], r_ring[NBITS_RING-1]};
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ring_nxt    = r_ring;
    w_rem_nxt     = r_remaining;
    w_counted_nxt = r_counted;
    w_presc_nxt   = r_presc_q;
    case (r_state)
      ST_IDLE: begin
        if (bus.stop) begin
          w_ring_nxt = '0;
        end else if (bus.start) begin
          w_state_nxt   = ST_RUN;
          w_ring_nxt    = RING_INIT;
          w_rem_nxt     = bus.steps;
          w_counted_nxt = (bus.steps != '0);
          w_presc_nxt   = bus.presc;
        end
      end
      ST_RUN, ST_HOLD: begin
        if (bus.stop) begin
          w_state_nxt = ST_IDLE;
          w_ring_nxt  = '0;
        end else if (bus.pause) begin
          w_state_nxt = ST_HOLD;
        end else begin
          w_state_nxt = ST_RUN;
          if (w_tick) begin
            w_ring_nxt = w_ring_step;
            if (r_counted) begin
              w_rem_nxt = r_remaining - 1'b1;
              if (r_remaining == NBITS_STEPS'(1)) begin
                w_state_nxt = ST_DONE;
              end
            end
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        if (bus.stop) begin
          w_ring_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_ring      <= '0;
      r_remaining <= '0;
      r_counted   <= 1'b0;
      r_presc_q   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ring      <= w_ring_nxt;
      r_remaining <= w_rem_nxt;
      r_counted   <= w_counted_nxt;
      r_presc_q   <= w_presc_nxt;
      r_busy      <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_HOLD);
      r_done      <= (w_state_nxt == ST_DONE);
    end
  end

  assign bus.ring  = r_ring;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.state = r_state;

endmodule

`default_nettype wire

// File: tb/tb_ring_sequencer.sv
//------------------------------------------------------------------------------
// tb_ring_sequencer: directed scoreboard bench for the ring sequencer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ring_sequencer;

  typedef struct packed {
    logic [3:0] ring;
    logic [1:0] state;
    logic       busy;
    logic       done;
  } exp_t;

  logic clk_2 = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  ring_sequencer_if #(.NBITS_STEPS(8), .NBITS_PRESC(8)) bus ();

  ring_sequencer #(.NBITS_STEPS(8), .NBITS_PRESC(8)) dut (
    .clk_2 (clk_2),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk_2 = ~clk_2;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queue the expectation, advance one edge, then pop and compare.
  task automatic cyc(input string tag, input logic [3:0] r, input logic [1:0] s,
                     input logic b, input logic d);
    exp_t e;
    sb.push_back('{ring: r, state: s, busy: b, done: d});
    @(posedge clk_2);
    #1;
    e = sb.pop_front();
    chk({tag, ".ring"},  bus.ring,         e.ring);
    chk({tag, ".state"}, {2'b00, bus.state}, {2'b00, e.state});
    chk({tag, ".busy"},  {3'b000, bus.busy}, {3'b000, e.busy});
    chk({tag, ".done"},  {3'b000, bus.done}, {3'b000, e.done});
  endtask

  initial begin
    logic [3:0] rexp;
    bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0; bus.dir = 1'b0;
    bus.steps = 8'd0; bus.presc = 8'd0;

    // Reset for two cycles
    cyc("rst0", 4'b0000, 2'd0, 1'b0, 1'b0);
    cyc("rst1", 4'b0000, 2'd0, 1'b0, 1'b0);
    reset = 1'b0;

    // Counted left run, 5 steps, presc 0
    bus.steps = 8'd5; bus.presc = 8'd0; bus.dir = 1'b0; bus.start = 1'b1;
    cyc("cl_start", 4'b0001, 2'd1, 1'b1, 1'b0);
    bus.start = 1'b0;
    cyc("cl_s1", 4'b0010, 2'd1, 1'b1, 1'b0);
    cyc("cl_s2", 4'b0100, 2'd1, 1'b1, 1'b0);
    cyc("cl_s3", 4'b1000, 2'd1, 1'b1, 1'b0);
    cyc("cl_s4", 4'b0001, 2'd1, 1'b1, 1'b0);
    cyc("cl_done", 4'b0010, 2'd3, 1'b0, 1'b1);
    cyc("cl_idle0", 4'b0010, 2'd0, 1'b0, 1'b0);
    cyc("cl_idle1", 4'b0010, 2'd0, 1'b0, 1'b0);

    // Continuous right with presc 2, then reverse mid-run
    bus.steps = 8'd0; bus.presc = 8'd2; bus.dir = 1'b1; bus.start = 1'b1;
    cyc("rp_start", 4'b0001, 2'd1, 1'b1, 1'b0);
    bus.start = 1'b0;
    cyc("rp_h1", 4'b0001, 2'd1, 1'b1, 1'b0);
    cyc("rp_h2", 4'b0001, 2'd1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc("rp_8", 4'b1000, 2'd1, 1'b1, 1'b0);
    cyc("rp_4a", 4'b0100, 2'd1, 1'b1, 1'b0);
    bus.dir = 1'b0;
    cyc("rp_4b", 4'b0100, 2'd1, 1'b1, 1'b0);
    cyc("rp_4c", 4'b0100, 2'd1, 1'b1, 1'b0);
    cyc("rp_rev", 4'b1000, 2'd1, 1'b1, 1'b0);
    bus.stop = 1'b1;
    cyc("rp_stop", 4'b0000, 2'd0, 1'b0, 1'b0);
    bus.stop = 1'b0;

    // Pause at pcnt=2 with presc 3 for ten cycles
    bus.presc = 8'd3; bus.start = 1'b1;
    cyc("pz_start", 4'b0001, 2'd1, 1'b1, 1'b0);
    bus.start = 1'b0;
    cyc("pz_p1", 4'b0001, 2'd1, 1'b1, 1'b0);
    cyc("pz_p2", 4'b0001, 2'd1, 1'b1, 1'b0);
    bus.pause = 1'b1;
    for (int i = 0; i < 10; i++) cyc("pz_hold", 4'b0001, 2'd2, 1'b1, 1'b0);
    bus.pause = 1'b0;
    cyc("pz_rel", 4'b0001, 2'd1, 1'b1, 1'b0);
    cyc("pz_step", 4'b0010, 2'd1, 1'b1, 1'b0);

    // Stop during HOLD, then start+stop together in IDLE
    bus.pause = 1'b1;
    cyc("ab_hold", 4'b0010, 2'd2, 1'b1, 1'b0);
    bus.stop = 1'b1;
    cyc("ab_stop", 4'b0000, 2'd0, 1'b0, 1'b0);
    bus.stop = 1'b0; bus.pause = 1'b0;
    cyc("ab_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    bus.start = 1'b1; bus.stop = 1'b1;
    cyc("ab_both", 4'b0000, 2'd0, 1'b0, 1'b0);
    bus.start = 1'b0; bus.stop = 1'b0;

    // Single-step run, stop asserted during DONE keeps the done pulse
    bus.steps = 8'd1; bus.presc = 8'd0; bus.start = 1'b1;
    cyc("d1_start", 4'b0001, 2'd1, 1'b1, 1'b0);
    bus.start = 1'b0;
    cyc("d1_done", 4'b0010, 2'd3, 1'b0, 1'b1);
    bus.stop = 1'b1;
    cyc("d1_stop", 4'b0000, 2'd0, 1'b0, 1'b0);
    bus.stop = 1'b0;

    // Continuous presc 0 for 20 cycles; a mid-run start must be ignored
    bus.steps = 8'd0; bus.presc = 8'd0; bus.dir = 1'b0; bus.start = 1'b1;
    cyc("ct_start", 4'b0001, 2'd1, 1'b1, 1'b0);
    bus.start = 1'b0;
    rexp = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin bus.start = 1'b1; bus.steps = 8'd3; bus.presc = 8'd4; end
      if (i == 6) bus.start = 1'b0;
      rexp = {rexp[2:0], rexp[3]};
      cyc("ct_run", rexp, 2'd1, 1'b1, 1'b0);
    end
    reset = 1'b1;
    cyc("ct_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    reset = 1'b0;
    cyc("ct_after", 4'b0000, 2'd0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ring_sequencer.md
# ring_sequencer

Controller that sequences the 4-bit one-hot ring counter driving LED[7:4] on the board top. It is started, paused and stopped from switch-derived controls. The step rate is set by a programmable prescaler. It runs either a fixed number of steps or continuously, in either direction. It replaces the free-running `unique case` ring logic with an explicit FSM, and reports `busy` and `done` status for display on the LCD/LED outputs.

## Interface
Parameters:
- NBITS_RING, 4, width of the one-hot ring.
- NBITS_STEPS, 8, width of the step-count operand.
- NBITS_PRESC, 8, width of the prescaler operand.

Ports:
- clk_2  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high; clock clk_2.
- start  in  1  level; honoured only in IDLE.
- stop  in  1  level; abort to IDLE, ring cleared.
- pause  in  1  level; freeze while high (RUN↔HOLD).
- dir  in  1  0 = rotate left (0001→0010), 1 = rotate right (0001→1000); sampled at each step.
- steps  in  NBITS_STEPS  step count, latched at start; 0 = continuous.
- presc  in  NBITS_PRESC  step period minus 1, latched at start.
- ring  out  NBITS_RING  one-hot ring value (to LED[7:4]).
- busy  out  1  high in RUN or HOLD.
- done  out  1  one-cycle pulse on completion of a counted run.
- state  out  2  current FSM state code (debug/LCD).

## Operation
- States and codes: IDLE=0, RUN=1, HOLD=2, DONE=3.
- Priority each edge: reset > stop > pause > step.
- reset: state IDLE, ring 0000, busy 0, done 0, prescale count 0, remaining 0.
- IDLE: ring keeps its last value.
  - start && !stop: enter RUN, ring←0001, remaining←steps, presc_q←presc, pcnt←0.
  - start && stop together: stay IDLE, ring←0000.
- RUN:
  - stop: enter IDLE, ring←0000, no done.
  - else pause: enter HOLD; ring and pcnt frozen.
  - else if pcnt==presc_q: step.
    - pcnt←0, ring rotates per dir.
    - If steps≠0, remaining decrements.
    - If remaining was 1, enter DONE on the same edge.
  - else pcnt←pcnt+1.
- HOLD:
  - stop: enter IDLE, ring←0000.
  - !pause: return to RUN; pcnt resumes from its frozen value.
- DONE: lasts one cycle with done=1 and ring holding the final value, then IDLE. stop in DONE: IDLE with ring←0000, and done is still asserted for that cycle.
- start while RUN, HOLD or DONE: ignored. steps and presc changes mid-run: ignored.
- Robustness: in RUN, a non-one-hot ring (not reachable) is forced to 0001 on the next step.
- Continuous mode (steps=0): wraps indefinitely; never enters DONE.

## Timing
- All outputs are registered; no combinational input→output paths.
- start at edge E: state=RUN and ring=0001 visible after E.
- First step occurs presc+1 edges after entry into RUN. The step period is presc+1 cycles, so presc=0 steps every cycle.
- Counted run: the ring holds 0001 for the start cycle, then changes `steps` times. done is high exactly in the cycle after the final step edge. Total run time is steps·(presc+1) cycles.
- pause has zero-cycle latency: the edge that samples pause=1 performs no step even if pcnt==presc_q. HOLD adds exactly its own duration to the schedule.
- Reset mid-operation: the next edge clears to IDLE and no done is generated.

## Structure
- Package ring_pkg holds:
  - the state_t enum (2-bit, codes above);
  - NBITS_RING;
  - the constant RING_INIT = 4'b0001.
- Sub-module tick_gen: a prescaler with enable (RUN), clear (entry to RUN), load value presc_q and a 1-cycle tick output. The FSM, step counter and ring register stay in ring_sequencer.

## Test plan
- Reset: reset=1 for 2 cycles → ring=0000, busy=0, done=0, state=0.
- Counted left run: steps=5, presc=0, dir=0, start pulse → ring 0001, 0010, 0100, 1000, 0001, 0010. done=1 for one cycle with ring=0010, then state=0, busy=0, ring stays 0010.
- Right with prescale: steps=0, presc=2, dir=1 → ring 0001 for 3 cycles, then 1000 for 3, then 0100. Flipping dir to 0 mid-run reverses at the next step.
- Pause: presc=3, pause high for 10 cycles after pcnt=2 → ring frozen and state=2. After release, the step occurs exactly 1 cycle later.
- Stop/abort: stop during HOLD → state=0, ring=0000, done never asserted. start+stop together in IDLE → stays IDLE.
- Continuous and reset mid-run: steps=0, presc=0, 20 cycles → ring wraps 5 times and done never asserted. start during RUN is ignored. reset mid-run → IDLE, ring=0000 on the next cycle.
